// File: rtl/bb_core_grid_pkg.sv
// Shared definitions for the BitBlade tile grid: precision codes, core FSM states and
// the tile-index width helper.
package bb_core_grid_pkg;

  localparam logic [1:0] PREC_2B = 2'b00;
  localparam logic [1:0] PREC_4B = 2'b01;
  localparam logic [1:0] PREC_8B = 2'b10;

  typedef enum logic [1:0] {
    StAcc,
    StWait,
    StDrain
  } state_e;

  // A single-tile grid still needs a 1-bit index port.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bb_tile_mac.sv
// One dot-product tile: per-operand precision sign-extension, LANES multipliers and an
// adder tree (stage 1), then a bias-seeded wrapping accumulator (stage 2).
module bb_tile_mac
  import bb_core_grid_pkg::*;
#(
  parameter int unsigned LANES  = 16,
  parameter int unsigned OP_W   = 8,
  parameter int unsigned BIAS_W = 16,
  parameter int unsigned PSUM_W = 24
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [OP_W*LANES-1:0]  act_i,
  input  logic [OP_W*LANES-1:0]  weight_i,
  input  logic [1:0]             act_prec_i,
  input  logic [1:0]             wt_prec_i,
  input  logic [BIAS_W-1:0]      bias_i,
  input  logic                   beat_i,
  input  logic                   sel_bias_i,
  output logic [PSUM_W-1:0]      acc_o
);

  localparam int unsigned ProdW = 2 * OP_W;
  localparam int unsigned DotW  = ProdW + $clog2(LANES) + 1;
  localparam int unsigned ExtA  = (DotW > PSUM_W) ? DotW : PSUM_W;
  localparam int unsigned ExtW  = (ExtA > BIAS_W) ? ExtA : BIAS_W;

  // Shift the live bits to the top, then arithmetic-shift back down.
  function automatic logic signed [OP_W-1:0] sext_field(logic [OP_W-1:0] f, logic [1:0] prec);
    int unsigned sh;
    case (prec)
      PREC_2B: sh = OP_W - 2;
      PREC_4B: sh = OP_W - 4;
      PREC_8B: sh = OP_W - 8;
      default: sh = OP_W - 8;
    endcase
    return $signed(f << sh) >>> sh;
  endfunction

  logic signed [DotW-1:0]   dot_d, dot_q;
  logic signed [BIAS_W-1:0] bias_q;
  logic signed [PSUM_W-1:0] acc_d, acc_q;
  logic signed [ExtW-1:0]   base;
  logic                     vld_q, sel_q;

  always_comb begin
    dot_d = '0;
    for (int l = 0; l < LANES; l++) begin
      dot_d = dot_d + DotW'(ProdW'(sext_field(act_i[l*OP_W +: OP_W], act_prec_i)) *
                            ProdW'(sext_field(weight_i[l*OP_W +: OP_W], wt_prec_i)));
    end
  end

  always_comb begin
    base  = sel_q ? ExtW'(bias_q) : ExtW'(acc_q);
    acc_d = PSUM_W'(base + ExtW'(dot_q));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dot_q  <= '0;
      bias_q <= '0;
      vld_q  <= 1'b0;
      sel_q  <= 1'b0;
      acc_q  <= '0;
    end else begin
      vld_q <= beat_i;
      // Bias travels with its beat so later bias changes cannot leak into stage 2.
      if (beat_i) begin
        dot_q  <= dot_d;
        sel_q  <= sel_bias_i;
        bias_q <= bias_i;
      end
      if (vld_q) acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/bb_core_grid.sv
// GRID_R x GRID_C BitBlade core: valid/ready beat intake, per-tile MAC pipelines and a
// serial back-pressured drain of one tile accumulator per handshake.
module bb_core_grid
  import bb_core_grid_pkg::*;
#(
  parameter int unsigned GRID_R = 4,
  parameter int unsigned GRID_C = 4,
  parameter int unsigned LANES  = 16,
  parameter int unsigned OP_W   = 8,
  parameter int unsigned BIAS_W = 16,
  parameter int unsigned PSUM_W = 24
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic [OP_W*LANES*GRID_C-1:0]         i_Act,
  input  logic [OP_W*LANES*GRID_R-1:0]         i_Weight,
  input  logic [1:0]                           i_Precision,
  input  logic [1:0]                           w_Precision,
  input  logic [BIAS_W*GRID_R*GRID_C-1:0]      i_Bias,
  input  logic                                 i_Sel_Bias,
  input  logic                                 i_Flush,
  input  logic                                 i_Vld,
  output logic                                 o_Rdy,
  output logic                                 o_Psum_Vld,
  input  logic                                 i_Psum_Rdy,
  output logic [PSUM_W-1:0]                    o_Psum,
  output logic [idx_w(GRID_R*GRID_C)-1:0]      o_Tile_Idx,
  output logic                                 o_Done
);

  localparam int unsigned NumTiles = GRID_R * GRID_C;
  localparam int unsigned IdxW     = idx_w(NumTiles);
  localparam int unsigned SliceW   = OP_W * LANES;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumTiles - 1);

  state_e            state_q;
  logic              wait_q;
  logic [IdxW-1:0]   idx_q, idx_next;
  logic [PSUM_W-1:0] psum_q;
  logic              psum_vld_q, done_q;
  logic              beat;
  logic [PSUM_W-1:0] acc_arr [NumTiles];

  assign o_Rdy    = (state_q == StAcc) && !RST;
  assign beat     = i_Vld && o_Rdy;
  assign idx_next = idx_q + IdxW'(1);

  for (genvar r = 0; r < GRID_R; r++) begin : g_row
    for (genvar c = 0; c < GRID_C; c++) begin : g_col
      bb_tile_mac #(
        .LANES  (LANES),
        .OP_W   (OP_W),
        .BIAS_W (BIAS_W),
        .PSUM_W (PSUM_W)
      ) u_tile (
        .clk_i      (CLK),
        .rst_i      (RST),
        .act_i      (i_Act[c*SliceW +: SliceW]),
        .weight_i   (i_Weight[r*SliceW +: SliceW]),
        .act_prec_i (i_Precision),
        .wt_prec_i  (w_Precision),
        .bias_i     (i_Bias[(r*GRID_C+c)*BIAS_W +: BIAS_W]),
        .beat_i     (beat),
        .sel_bias_i (i_Sel_Bias),
        .acc_o      (acc_arr[r*GRID_C+c])
      );
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StAcc;
      wait_q     <= 1'b0;
      idx_q      <= '0;
      psum_q     <= '0;
      psum_vld_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StAcc: begin
          if (beat && i_Flush) begin
            state_q <= StWait;
            wait_q  <= 1'b0;
          end
        end
        // Two cycles let the flush beat pass stage 1 and commit in stage 2.
        StWait: begin
          if (wait_q) begin
            state_q    <= StDrain;
            idx_q      <= '0;
            psum_q     <= acc_arr[0];
            psum_vld_q <= 1'b1;
          end else begin
            wait_q <= 1'b1;
          end
        end
        StDrain: begin
          if (i_Psum_Rdy) begin
            if (idx_q == LastIdx) begin
              state_q    <= StAcc;
              idx_q      <= '0;
              psum_q     <= '0;
              psum_vld_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              idx_q  <= idx_next;
              psum_q <= acc_arr[idx_next];
            end
          end
        end
        default: state_q <= StAcc;
      endcase
    end
  end

  assign o_Psum_Vld = psum_vld_q;
  assign o_Psum     = psum_q;
  assign o_Tile_Idx = idx_q;
  assign o_Done     = done_q;

endmodule
